id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage for the five-stage MIPS pipeline. It registers the decoded control word and the operand/immediate/register-specifier fields from ID into EX. It also contains load-use hazard detection, which drives the PC and IF/ID write enables and inserts a bubble. It sits directly downstream of the combinational opcode control decoder and register file, and directly upstream of the EX stage, ALU control and forwarding unit.

## Interface
Parameters:
- `DW`, default 32: datapath width for PC+4, operands and immediate.
- `CW`, default 16: stall counter width.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `id_RegDst`, `id_ALUSrc`, `id_MemtoReg`, `id_RegWrite`, `id_MemRead`, `id_MemWrite`, `id_Branch`  in  1 each  decoded control from the opcode decoder.
- `id_ALUOp`  in  2  ALU operation class from the decoder.
- `id_valid`  in  1  IF/ID holds a real instruction.
- `id_pc4`  in  DW  PC+4 of the ID instruction.
- `id_rd1`, `id_rd2`  in  DW  register file read data.
- `id_imm`  in  DW  sign-extended immediate.
- `id_rs`, `id_rt`, `id_rd`  in  5 each  register specifiers.
- `flush`  in  1  branch taken in MEM; squash the ID instruction.
- `ex_RegDst`, `ex_ALUSrc`, `ex_MemtoReg`, `ex_RegWrite`, `ex_MemRead`, `ex_MemWrite`, `ex_Branch`  out  1 each  registered control.
- `ex_ALUOp`  out  2  registered ALUOp.
- `ex_valid`  out  1  EX holds a real, unsquashed instruction.
- `ex_pc4`, `ex_rd1`, `ex_rd2`, `ex_imm`  out  DW  registered data.
- `ex_rs`, `ex_rt`, `ex_rd`  out  5 each  registered specifiers.
- `stall`  out  1  load-use hazard detected this cycle (combinational).
- `pc_write`  out  1  PC write enable, `~stall`.
- `ifid_write`  out  1  IF/ID write enable, `~stall`.
- `stall_cnt`  out  CW  saturating count of stall cycles.

## Operation
- Hazard condition: `raw_hz = ex_MemRead & ex_valid & id_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt))`.
- Stall: `stall = raw_hz & ~flush`. Flush wins because a wrong-path instruction must not freeze fetch.
- Bubble load: when `stall | flush | ~id_valid`, the next edge loads all nine control bits as 0 (ALUOp = 00) and `ex_valid` as 0.
- On a bubble, the data and specifier registers still load the ID values. Downstream logic must qualify them with the zeroed control.
- Normal load: otherwise every `ex_*` register takes its `id_*` counterpart, and `ex_valid` becomes 1.
- The X values the decoder emits for sw/beq (RegDst, MemtoReg) are registered as 0. No X propagates out of this stage.
- Counter: `stall_cnt` increments by 1 on each edge where `stall` is 1. It holds at all-ones (saturates, no wrap).
- Reset (`reset_n` = 0, asynchronous): all `ex_*` outputs become 0, `ex_valid` becomes 0, and `stall_cnt` becomes 0.
- Because `ex_valid` = 0 during reset, `stall` = 0 and `pc_write` = `ifid_write` = 1.
- Reset deassertion mid-operation: the first edge after release is a normal load from the ID inputs.

## Timing
- Latency: ID inputs appear on `ex_*` one `clk` edge later.
- `stall`, `pc_write` and `ifid_write` are combinational from the current `ex_*` registers and the ID inputs, valid within the same cycle. There is no registered delay.
- A load-use pair produces exactly one stall cycle:
  - cycle N: lw is in EX and the consumer is in ID; `stall` = 1.
  - edge N+1: a bubble enters EX, the consumer is held in ID, and lw moves on, so `ex_MemRead` = 0.
  - cycle N+1: `stall` = 0.
- Back-to-back lw followed by a dependent lw: each dependency stalls independently, one cycle each.
- `flush` and `stall` together: `stall` = 0, a bubble is loaded, and `stall_cnt` is unchanged.

## Test plan
- Reset: assert `reset_n` = 0 mid-cycle with nonzero `ex_*` → all outputs 0 immediately (asynchronous), `pc_write` = 1, `stall_cnt` = 0.
- R-format pass-through: `id_RegDst` = 1, `id_RegWrite` = 1, ALUOp = 10, `id_rd1` = 0x12345678, `id_rd` = 5 → next edge shows the same values on `ex_*`, `ex_valid` = 1, `stall` = 0.
- Load-use: lw rt=8 in EX, then ID has rs=8 → `stall` = 1, `pc_write` = `ifid_write` = 0. The next edge loads `ex_RegWrite` = 0, `ex_valid` = 0, and `stall_cnt` goes 0→1. The following cycle shows `stall` = 0.
- $zero exemption: lw rt=0 in EX, then ID has rs=0 → `stall` = 0 and a normal load.
- Flush precedence: the load-use condition plus `flush` = 1 → `stall` = 0, `pc_write` = 1, a bubble is loaded, and `stall_cnt` is unchanged.
- Saturation: with CW = 4, hold the hazard for 20 cycles → `stall_cnt` stops at 15.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating stall-cycle counter.
module id_ex_stage #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          id_RegDst,
    input  logic          id_ALUSrc,
    input  logic          id_MemtoReg,
    input  logic          id_RegWrite,
    input  logic          id_MemRead,
    input  logic          id_MemWrite,
    input  logic          id_Branch,
    input  logic [1:0]    id_ALUOp,
    input  logic          id_valid,
    input  logic [DW-1:0] id_pc4,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_rd,
    input  logic          flush,
    output logic          ex_RegDst,
    output logic          ex_ALUSrc,
    output logic          ex_MemtoReg,
    output logic          ex_RegWrite,
    output logic          ex_MemRead,
    output logic          ex_MemWrite,
    output logic          ex_Branch,
    output logic [1:0]    ex_ALUOp,
    output logic          ex_valid,
    output logic [DW-1:0] ex_pc4,
    output logic [DW-1:0] ex_rd1,
    output logic [DW-1:0] ex_rd2,
    output logic [DW-1:0] ex_imm,
    output logic [4:0]    ex_rs,
    output logic [4:0]    ex_rt,
    output logic [4:0]    ex_rd,
    output logic          stall,
    output logic          pc_write,
    output logic          ifid_write,
    output logic [CW-1:0] stall_cnt
);

    logic raw_hz;
    logic bubble;

    assign raw_hz = ex_MemRead & ex_valid & id_valid & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (ex_rt == id_rt));
    // A wrong-path instruction being squashed must never freeze fetch.
    assign stall      = raw_hz & ~flush;
    assign pc_write   = ~stall;
    assign ifid_write = ~stall;
    assign bubble     = stall | flush | ~id_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_RegDst   <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_ALUOp    <= 2'b00;
            ex_valid    <= 1'b0;
        end else if (bubble) begin
            ex_RegDst   <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_ALUOp    <= 2'b00;
            ex_valid    <= 1'b0;
        end else begin
            // RegDst/MemtoReg are don't-care (X) unless the instruction writes back.
            ex_RegDst   <= id_RegDst & id_RegWrite;
            ex_ALUSrc   <= id_ALUSrc;
            ex_MemtoReg <= id_MemtoReg & id_RegWrite;
            ex_RegWrite <= id_RegWrite;
            ex_MemRead  <= id_MemRead;
            ex_MemWrite <= id_MemWrite;
            ex_Branch   <= id_Branch;
            ex_ALUOp    <= id_ALUOp;
            ex_valid    <= 1'b1;
        end
    end

    // Data fields load even on a bubble; the zeroed control qualifies them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_pc4 <= '0;
            ex_rd1 <= '0;
            ex_rd2 <= '0;
            ex_imm <= '0;
            ex_rs  <= 5'd0;
            ex_rt  <= 5'd0;
            ex_rd  <= 5'd0;
        end else begin
            ex_pc4 <= id_pc4;
            ex_rd1 <= id_rd1;
            ex_rd2 <= id_rd2;
            ex_imm <= id_imm;
            ex_rs  <= id_rs;
            ex_rt  <= id_rt;
            ex_rd  <= id_rd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CW{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (CW = 4 to reach saturation quickly).
module tb_id_ex_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          reset_n;
    logic          id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite;
    logic          id_MemRead, id_MemWrite, id_Branch;
    logic [1:0]    id_ALUOp;
    logic          id_valid;
    logic [DW-1:0] id_pc4, id_rd1, id_rd2, id_imm;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic          flush;
    logic          ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite;
    logic          ex_MemRead, ex_MemWrite, ex_Branch;
    logic [1:0]    ex_ALUOp;
    logic          ex_valid;
    logic [DW-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic          stall, pc_write, ifid_write;
    logic [CW-1:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    id_ex_stage #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .id_Branch(id_Branch), .id_ALUOp(id_ALUOp), .id_valid(id_valid),
        .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_Branch(ex_Branch), .ex_ALUOp(ex_ALUOp), .ex_valid(ex_valid),
        .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        id_RegDst = 1'b0; id_ALUSrc = 1'b0; id_MemtoReg = 1'b0; id_RegWrite = 1'b0;
        id_MemRead = 1'b0; id_MemWrite = 1'b0; id_Branch = 1'b0; id_ALUOp = 2'b00;
    endtask

    task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt);
        clear_ctrl();
        id_ALUSrc = 1'b1; id_MemtoReg = 1'b1; id_RegWrite = 1'b1; id_MemRead = 1'b1;
        id_rs = rs; id_rt = rt; id_rd = 5'd0; id_valid = 1'b1;
    endtask

    task automatic set_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        clear_ctrl();
        id_RegDst = 1'b1; id_RegWrite = 1'b1; id_ALUOp = 2'b10;
        id_rs = rs; id_rt = rt; id_rd = rd; id_valid = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; id_valid = 1'b0;
        clear_ctrl();
        id_pc4 = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
        #2;
        check_eq("rst_valid", ex_valid, 0);
        check_eq("rst_cnt", stall_cnt, 0);
        check_eq("rst_pcw", pc_write, 1);
        #10 reset_n = 1'b1;

        // R-format pass-through
        set_r(5'd1, 5'd2, 5'd5);
        id_rd1 = 32'h1234_5678; id_rd2 = 32'hCAFE_F00D; id_imm = 32'h10; id_pc4 = 32'h104;
        step();
        check_eq("r_regdst", ex_RegDst, 1);
        check_eq("r_regwrite", ex_RegWrite, 1);
        check_eq("r_aluop", ex_ALUOp, 2'b10);
        check_eq("r_rd1", ex_rd1, 32'h1234_5678);
        check_eq("r_rd2", ex_rd2, 32'hCAFE_F00D);
        check_eq("r_pc4", ex_pc4, 32'h104);
        check_eq("r_rd", ex_rd, 5);
        check_eq("r_valid", ex_valid, 1);
        check_eq("r_stall", stall, 0);

        // Load-use: lw rt=8, then consumer rs=8
        set_lw(5'd3, 5'd8);
        step();
        check_eq("lw_memread", ex_MemRead, 1);
        set_r(5'd8, 5'd9, 5'd10);
        #1;
        check_eq("lu_stall", stall, 1);
        check_eq("lu_pcw", pc_write, 0);
        check_eq("lu_ifidw", ifid_write, 0);
        step();
        check_eq("lu_bub_regwrite", ex_RegWrite, 0);
        check_eq("lu_bub_valid", ex_valid, 0);
        check_eq("lu_bub_memread", ex_MemRead, 0);
        check_eq("lu_bub_rs", ex_rs, 8);
        check_eq("lu_cnt", stall_cnt, 1);
        check_eq("lu_stall_after", stall, 0);
        step();
        check_eq("lu_cons_valid", ex_valid, 1);
        check_eq("lu_cons_regwrite", ex_RegWrite, 1);

        // $zero exemption
        set_lw(5'd3, 5'd0);
        step();
        set_r(5'd0, 5'd0, 5'd11);
        #1;
        check_eq("z_stall", stall, 0);
        step();
        check_eq("z_valid", ex_valid, 1);
        check_eq("z_rd", ex_rd, 11);
        check_eq("z_cnt", stall_cnt, 1);

        // Flush wins over load-use
        set_lw(5'd3, 5'd8);
        step();
        set_r(5'd8, 5'd9, 5'd12);
        flush = 1'b1;
        #1;
        check_eq("fl_stall", stall, 0);
        check_eq("fl_pcw", pc_write, 1);
        step();
        flush = 1'b0;
        check_eq("fl_valid", ex_valid, 0);
        check_eq("fl_regwrite", ex_RegWrite, 0);
        check_eq("fl_cnt", stall_cnt, 1);

        // sw with X don't-cares on RegDst/MemtoReg
        clear_ctrl();
        id_RegDst = 1'bx; id_MemtoReg = 1'bx; id_ALUSrc = 1'b1; id_MemWrite = 1'b1;
        id_rs = 5'd4; id_rt = 5'd6; id_valid = 1'b1;
        step();
        check_eq("sw_regdst", ex_RegDst, 0);
        check_eq("sw_memtoreg", ex_MemtoReg, 0);
        check_eq("sw_memwrite", ex_MemWrite, 1);

        // Invalid ID instruction loads a bubble
        set_r(5'd1, 5'd2, 5'd3);
        id_valid = 1'b0;
        step();
        check_eq("inv_valid", ex_valid, 0);
        check_eq("inv_regwrite", ex_RegWrite, 0);

        // lw followed by dependent lw, then dependent consumer
        set_lw(5'd3, 5'd8);
        step();
        set_lw(5'd8, 5'd9);
        #1;
        check_eq("bb_stall1", stall, 1);
        step();
        check_eq("bb_cnt1", stall_cnt, 2);
        check_eq("bb_nostall1", stall, 0);
        step();
        set_r(5'd9, 5'd1, 5'd2);
        #1;
        check_eq("bb_stall2", stall, 1);
        step();
        check_eq("bb_cnt2", stall_cnt, 3);

        // Repeated load-use pairs drive the counter into saturation
        for (int i = 0; i < 20; i++) begin
            set_lw(5'd3, 5'd7);
            step();
            set_r(5'd1, 5'd7, 5'd2);
            step();
            if (i == 4) check_eq("sat_mid", stall_cnt, 8);
        end
        check_eq("sat_cnt", stall_cnt, 15);

        // Asynchronous reset mid-cycle with live state
        set_r(5'd1, 5'd2, 5'd5);
        id_rd1 = 32'hA5A5_0001;
        step();
        check_eq("pre_rst_valid", ex_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("ar_valid", ex_valid, 0);
        check_eq("ar_rd1", ex_rd1, 0);
        check_eq("ar_regwrite", ex_RegWrite, 0);
        check_eq("ar_cnt", stall_cnt, 0);
        check_eq("ar_pcw", pc_write, 1);
        #3 reset_n = 1'b1;
        step();
        check_eq("post_rst_valid", ex_valid, 1);
        check_eq("post_rst_rd1", ex_rd1, 32'hA5A5_0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
